// File: rtl/oled_screen_sequencer.sv
// oled_screen_sequencer: owns the OLED screen-select code. Button edges latch a
// single navigation request, which is committed only on a frame boundary.
// After each switch the panel is blanked for a few frames. After an idle
// period away from home, the sequencer returns to the home screen.
module oled_screen_sequencer #(
    parameter int                    NUM_STATES     = 11,
    parameter logic [NUM_STATES-1:0] VALID_MASK     = 11'b111_0111_1011,
    parameter int                    HOME_STATE     = 0,
    parameter int                    BLANK_FRAMES   = 2,
    parameter int                    TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_home,
    input  logic       frame_begin,
    output logic [3:0] machine_state,
    output logic       pending,
    output logic       switch_pulse,
    output logic       blank
);

    localparam int CNT_W  = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [15:0]       MASK16    = 16'(VALID_MASK);
    localparam logic [3:0]        HOME      = 4'(HOME_STATE);
    localparam logic [IDLE_W-1:0] IDLE_LAST = (TIMEOUT_CYCLES > 0) ? IDLE_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [IDLE_W-1:0] IDLE_MAX  = '1;

    typedef enum logic [1:0] {REQ_NEXT, REQ_PREV, REQ_HOME} req_kind_t;
    typedef enum logic {S_IDLE, S_BLANKING} fsm_t;

    fsm_t              fsm;
    logic              btn_next_q, btn_prev_q, btn_home_q;
    logic              req_valid;
    req_kind_t         req_kind;
    logic [CNT_W-1:0]  cnt;
    logic [IDLE_W-1:0] idle_cnt;

    logic      e_next, e_prev, e_home, any_edge;
    req_kind_t edge_kind;
    logic [3:0] target;
    logic [4:0] idx;
    logic      serve, inject;

    assign e_next   = btn_next & ~btn_next_q;
    assign e_prev   = btn_prev & ~btn_prev_q;
    assign e_home   = btn_home & ~btn_home_q;
    assign any_edge = e_next | e_prev | e_home;
    assign pending  = req_valid;

    // Edge priority when several buttons rise together: home > next > prev.
    always_comb begin
        edge_kind = REQ_PREV;
        if (e_next) edge_kind = REQ_NEXT;
        if (e_home) edge_kind = REQ_HOME;
    end

    // Target scan: walk offsets from far to near so the nearest valid code wins.
    always_comb begin
        target = machine_state;
        idx    = '0;
        case (req_kind)
            REQ_NEXT: begin
                for (int k = NUM_STATES - 1; k >= 1; k--) begin
                    idx = {1'b0, machine_state} + 5'(k);
                    if (idx >= 5'(NUM_STATES)) idx = idx - 5'(NUM_STATES);
                    if (MASK16[idx[3:0]]) target = idx[3:0];
                end
            end
            REQ_PREV: begin
                for (int k = NUM_STATES - 1; k >= 1; k--) begin
                    idx = {1'b0, machine_state} + 5'(NUM_STATES) - 5'(k);
                    if (idx >= 5'(NUM_STATES)) idx = idx - 5'(NUM_STATES);
                    if (MASK16[idx[3:0]]) target = idx[3:0];
                end
            end
            default: target = HOME;
        endcase
    end

    // A request is served only if it was latched before this frame_begin. The
    // idle timeout injects a home request only when no user request is waiting.
    always_comb begin
        serve  = (fsm == S_IDLE) && frame_begin && req_valid;
        inject = (TIMEOUT_CYCLES > 0) && (machine_state != HOME) && !any_edge &&
                 (idle_cnt == IDLE_LAST) && !req_valid;
    end

    // Sequencer state: button history, request latch, screen FSM, idle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm           <= S_IDLE;
            btn_next_q    <= 1'b1;
            btn_prev_q    <= 1'b1;
            btn_home_q    <= 1'b1;
            req_valid     <= 1'b0;
            req_kind      <= REQ_HOME;
            cnt           <= '0;
            idle_cnt      <= '0;
            machine_state <= HOME;
            switch_pulse  <= 1'b0;
            blank         <= 1'b0;
        end else begin
            btn_next_q   <= btn_next;
            btn_prev_q   <= btn_prev;
            btn_home_q   <= btn_home;
            switch_pulse <= 1'b0;

            // The newest edge always wins, even in the cycle a request is served.
            if (any_edge) begin
                req_valid <= 1'b1;
                req_kind  <= edge_kind;
            end else if (serve) begin
                req_valid <= 1'b0;
            end else if (inject) begin
                req_valid <= 1'b1;
                req_kind  <= REQ_HOME;
            end

            case (fsm)
                S_IDLE: begin
                    // A request that resolves to the current screen just clears.
                    if (serve && target != machine_state) begin
                        machine_state <= target;
                        switch_pulse  <= 1'b1;
                        if (BLANK_FRAMES > 0) begin
                            blank <= 1'b1;
                            cnt   <= CNT_W'(BLANK_FRAMES);
                            fsm   <= S_BLANKING;
                        end
                    end
                end
                S_BLANKING: begin
                    if (frame_begin) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            blank <= 1'b0;
                            fsm   <= S_IDLE;
                        end
                    end
                end
                default: fsm <= S_IDLE;
            endcase

            if (TIMEOUT_CYCLES == 0 || machine_state == HOME || any_edge)
                idle_cnt <= '0;
            else if (idle_cnt == IDLE_LAST)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX)
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_oled_screen_sequencer.sv
// Bench for oled_screen_sequencer: table-driven navigation and hand-written
// corner sequences. Expected screen codes are queued when a switch is provoked
// and popped whenever switch_pulse is seen.
module tb_oled_screen_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_next = 1'b0, btn_prev = 1'b0, btn_home = 1'b0;
    logic       frame_begin = 1'b0;
    logic [3:0] machine_state;
    logic       pending, switch_pulse, blank;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int exp_q[$];

    oled_screen_sequencer #(
        .NUM_STATES    (11),
        .VALID_MASK    (11'b111_0111_1011),
        .HOME_STATE    (0),
        .BLANK_FRAMES  (2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_next     (btn_next),
        .btn_prev     (btn_prev),
        .btn_home     (btn_home),
        .frame_begin  (frame_begin),
        .machine_state(machine_state),
        .pending      (pending),
        .switch_pulse (switch_pulse),
        .blank        (blank)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Every switch_pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (switch_pulse) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_switch: got state %0d, expected no switch", machine_state);
            end else begin
                chk("switch_state", int'(machine_state), exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_begin = 1'b1;
        step();
        frame_begin = 1'b0;
        step();
    endtask

    // which: 0 = next, 1 = prev, 2 = home
    task automatic press(input int which);
        btn_next = (which == 0);
        btn_prev = (which == 1);
        btn_home = (which == 2);
        step();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        btn_home = 1'b0;
        step();
    endtask

    task automatic nav(input int which, input int exp);
        press(which);
        chk("pending_after_press", int'(pending), 1);
        exp_q.push_back(exp);
        frame();
        chk("nav_state", int'(machine_state), exp);
        chk("nav_blank_on", int'(blank), 1);
        chk("nav_pending_clr", int'(pending), 0);
        frame();
        frame();
        chk("nav_blank_off", int'(blank), 0);
    endtask

    typedef struct {
        int which;
        int exp;
    } vec_t;

    vec_t tbl[14];
    int   t0;

    initial begin
        tbl[0]  = '{0, 1};  tbl[1]  = '{0, 3};  tbl[2]  = '{0, 4};
        tbl[3]  = '{0, 5};  tbl[4]  = '{0, 6};  tbl[5]  = '{0, 8};
        tbl[6]  = '{0, 9};  tbl[7]  = '{0, 10}; tbl[8]  = '{0, 0};
        tbl[9]  = '{1, 10}; tbl[10] = '{1, 9};  tbl[11] = '{2, 0};
        tbl[12] = '{1, 10}; tbl[13] = '{0, 0};

        // Reset with next held: must not fire on release of reset.
        btn_next = 1'b1;
        step();
        step();
        chk("rst_state", int'(machine_state), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_blank", int'(blank), 0);
        chk("rst_pulse", int'(switch_pulse), 0);
        rst_n = 1'b1;
        step();
        frame();
        chk("held_btn_no_req", int'(pending), 0);
        chk("held_btn_state", int'(machine_state), 0);
        btn_next = 1'b0;
        step();

        // Navigation table: skips of 2 and 7, wrap in both directions, home.
        for (int i = 0; i < 14; i++) nav(tbl[i].which, tbl[i].exp);

        // Blank window and a press during blanking, served at F+3.
        press(0);
        exp_q.push_back(1);
        frame();
        chk("blank_f0", int'(blank), 1);
        frame();
        chk("blank_f1", int'(blank), 1);
        press(0);
        frame();
        chk("blank_f2_off", int'(blank), 0);
        chk("blank_held_state", int'(machine_state), 1);
        chk("blank_held_pending", int'(pending), 1);
        exp_q.push_back(3);
        frame();
        chk("blank_f3_state", int'(machine_state), 3);
        frame();
        frame();

        // Simultaneous home + next from 4 resolves to home.
        nav(0, 4);
        btn_home = 1'b1;
        btn_next = 1'b1;
        step();
        btn_home = 1'b0;
        btn_next = 1'b0;
        step();
        exp_q.push_back(0);
        frame();
        chk("home_prio", int'(machine_state), 0);
        frame();
        frame();

        // Next then prev before a frame from 4: last request wins.
        nav(0, 1);
        nav(0, 3);
        nav(0, 4);
        press(0);
        press(1);
        exp_q.push_back(3);
        frame();
        chk("last_wins", int'(machine_state), 3);
        frame();
        frame();
        nav(2, 0);

        // Home while at home: request clears, no switch, no blank.
        press(2);
        chk("home_at_home_pend", int'(pending), 1);
        frame();
        chk("home_at_home_clr", int'(pending), 0);
        chk("home_at_home_state", int'(machine_state), 0);
        chk("home_at_home_blank", int'(blank), 0);

        // Idle timeout from state 5.
        nav(0, 1);
        nav(0, 3);
        nav(0, 4);
        btn_next = 1'b1;
        step();
        t0 = cyc;
        btn_next = 1'b0;
        exp_q.push_back(5);
        step();
        frame();
        frame();
        frame();
        chk("to_state5", int'(machine_state), 5);
        while (!pending && (cyc - t0) < 300) step();
        chk("timeout_latency", cyc - t0, 100);
        exp_q.push_back(0);
        frame();
        chk("timeout_home", int'(machine_state), 0);
        frame();
        frame();
        repeat (150) step();
        chk("no_timeout_at_home", int'(pending), 0);

        // Reset during blanking with a request pending.
        press(0);
        exp_q.push_back(1);
        frame();
        press(0);
        chk("pre_rst_pending", int'(pending), 1);
        chk("pre_rst_blank", int'(blank), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_state", int'(machine_state), 0);
        chk("mid_rst_blank", int'(blank), 0);
        chk("mid_rst_pending", int'(pending), 0);
        chk("mid_rst_pulse", int'(switch_pulse), 0);
        step();
        frame();
        frame();
        chk("post_rst_state", int'(machine_state), 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/oled_screen_sequencer.md
Name: oled_screen_sequencer

Overview:
- Owns the 4-bit machine_state that drives the OLED screen mux; replaces ad-hoc state writes from the button logic.
- Takes debounced next/prev/home button levels and latches one navigation request at a time.
- Commits the request only on a frame boundary from the OLED driver, so a frame never mixes two screens.
- Skips unused state codes, blanks the panel for a set number of frames after each switch, and returns to the home screen after an idle timeout.

Parameters:
- NUM_STATES, 11, number of state codes scanned (0..NUM_STATES-1), max 16.
- VALID_MASK, 11'b111_0111_1011, bit i = 1 means state i is a real screen (states 2 and 7 unused).
- HOME_STATE, 0, reset/home screen code; must have its VALID_MASK bit set.
- BLANK_FRAMES, 2, full frames of blank after a switch; 0 disables blanking.
- TIMEOUT_CYCLES, 500_000_000, clk cycles without an accepted button edge before auto-home; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- btn_next  in  1  debounced level, advance to next valid screen
- btn_prev  in  1  debounced level, go to previous valid screen
- btn_home  in  1  debounced level, go to HOME_STATE
- frame_begin  in  1  one-cycle pulse from the OLED driver at pixel index 0
- machine_state  out  4  registered current screen code, feeds the screen mux
- pending  out  1  registered, high while a request is latched and not yet applied
- switch_pulse  out  1  registered, one-cycle pulse in the cycle after machine_state changes
- blank  out  1  registered, high while the screen mux output must be forced to 0

Behaviour:
- Reset (rst_n = 0 at posedge clk):
  - machine_state = HOME_STATE; pending, switch_pulse and blank = 0.
  - Blank counter and idle counter = 0; FSM = IDLE.
  - Button history registers = 1, so a button held through reset does not fire.
  - Reset mid-blank or mid-pending discards everything.
- Edge detect:
  - A rising edge on a button is valid for one cycle.
  - If several edges arrive in the same cycle, priority is home > next > prev.
- Request register (req_valid, req_kind):
  - A valid edge sets it; a later edge overwrites an unserved request (last wins).
  - pending = req_valid.
  - An edge in the same cycle that a request is applied is latched as the new request.
- Target computation (combinational from machine_state and req_kind):
  - next: smallest valid index above current, wrapping modulo NUM_STATES.
  - prev: largest valid index below current, wrapping.
  - home: HOME_STATE.
  - If the target equals the current state (home while home, or a single valid state), the request is cleared with no switch, no pulse and no blank.
- FSM IDLE:
  - On frame_begin with req_valid registered from an earlier cycle: machine_state <= target, clear req.
  - switch_pulse is 1 in the next cycle.
  - If BLANK_FRAMES > 0: blank <= 1, cnt <= BLANK_FRAMES, go to BLANKING.
  - An edge arriving in the same cycle as frame_begin is not served that frame. Minimum latency from edge to switch is the next frame_begin after the latch cycle.
- FSM BLANKING:
  - Requests latch but are not served.
  - Each frame_begin decrements cnt. On the frame_begin where cnt goes 1 -> 0: blank <= 0, FSM -> IDLE.
  - blank therefore spans exactly BLANK_FRAMES full frames after the switching frame.
  - A held request is served at the following frame_begin.
- Idle timeout:
  - idle_cnt increments every cycle and clears on any accepted edge.
  - It is held at 0 while machine_state == HOME_STATE.
  - When idle_cnt reaches TIMEOUT_CYCLES-1 and req_valid = 0, a home request is injected and idle_cnt clears.
  - If a user request is already pending at that point, nothing is injected and idle_cnt clears.
  - idle_cnt width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.

Test Plan:
- Reset with btn_next held high, release, press again, then frame_begin -> no switch before the re-press; after it, machine_state 0 -> 1, one switch_pulse.
- From state 1, press next, then frame_begin -> machine_state = 3 (2 skipped). From state 6, next -> 8. From state 10, next -> 0 (wrap). From state 0, prev -> 10.
- With BLANK_FRAMES = 2, a switch at frame F -> blank high from F+1 cycle until the cycle after frame F+2's frame_begin. A next press during blank applies at frame F+3.
- Home and next edges in the same cycle from state 4 -> target 0. Next then prev before a frame from state 4 -> 3 (last wins). Home while at 0 -> pending clears at frame_begin, machine_state stays 0, no switch_pulse, no blank.
- TIMEOUT_CYCLES = 100, at state 5 with no presses -> pending rises at cycle 100; next frame_begin sets machine_state = 0. At state 0 the counter stays 0 and nothing is injected.
- rst_n low for one cycle during BLANKING with a request pending -> next cycle machine_state = 0, blank = 0, pending = 0, no switch_pulse.
